imem_loader: RTL and testbench

Host-side instruction loader for the 16-bit, 8-word processor. It accepts a valid/ready word stream and writes the words into instruction memory while holding the processor in reset. It then releases reset and issues a one-cycle `pc_manual_override` pulse so the processor starts at a host-chosen PC. It sits between the host/debug port and the processor's `rst`, `manual_pc` and `pc_manual_override` inputs, and is the writer for the instruction memory the processor reads.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Host-side instruction loader: streams words into instruction memory while the
// processor is held in reset, then releases it with a one-cycle PC override.
module imem_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              pc_manual_override,
  output logic [ADDR_W-1:0] manual_pc,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD, S_DRAIN, S_KICK, S_RUN, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  start_pc_q, start_pc_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               override_q, override_d;
  logic [ADDR_W-1:0]  manual_pc_q, manual_pc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               beat;

  assign beat = in_valid && in_ready_q;

  // Next-state and next-output logic; outputs derive from the state being entered.
  always_comb begin
    state_d      = state_q;
    start_pc_d   = start_pc_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    manual_pc_d  = manual_pc_q;

    unique case (state_q)
      S_IDLE: if (load_start) state_d = S_HEADER;
      S_HEADER: begin
        if (beat) begin
          start_pc_d = in_data[ADDR_W-1:0];
          state_d    = in_last ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (word_count_q == CNT_W'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            mem_we_d     = 1'b1;
            mem_addr_d   = word_count_q[ADDR_W-1:0];
            mem_wdata_d  = in_data;
            word_count_d = word_count_q + CNT_W'(1);
            if (in_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_KICK;
      S_KICK:  state_d = S_RUN;
      S_RUN, S_ERR: if (load_start) state_d = S_HEADER;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_HEADER && state_q != S_HEADER) word_count_d = '0;
    if (state_d == S_KICK) manual_pc_d = start_pc_d;

    in_ready_d = (state_d == S_HEADER) || (state_d == S_LOAD);
    busy_d     = in_ready_d;
    cpu_rst_d  = !((state_d == S_KICK) || (state_d == S_RUN));
    override_d = (state_d == S_KICK);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      start_pc_q   <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      override_q   <= 1'b0;
      manual_pc_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pc_q   <= start_pc_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      override_q   <= override_d;
      manual_pc_q  <= manual_pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign cpu_rst            = cpu_rst_q;
  assign pc_manual_override = override_q;
  assign manual_pc          = manual_pc_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_overflow       = err_q;
  assign word_count         = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: drives host streams and compares writes,
// kick timing and the resulting memory image against a simple image model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        pc_manual_override;
  logic [2:0]  manual_pc;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic [3:0]  word_count;

  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .pc_manual_override(pc_manual_override), .manual_pc(manual_pc),
    .busy(busy), .done(done), .err_overflow(err_overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] stim_q[$];
  logic [2:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  int          ovr_cnt = 0;
  logic [15:0] tb_mem [8];
  logic [15:0] exp_mem[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe every memory write and override cycle the DUT produces.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      tb_mem[mem_addr] = mem_wdata;
    end
    if (rst && pc_manual_override) ovr_cnt++;
  end

  task automatic start_load();
    @(negedge clk);
    obs_addr.delete();
    obs_data.delete();
    ovr_cnt = 0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_done", done, 0);
    chk("start_err", err_overflow, 0);
    chk("start_wc", word_count, 0);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l, input int g);
    int to;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    to = 0;
    while (!in_ready && to < 20) begin
      @(negedge clk);
      to++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Loads header + stim_q; the model expects min(n,8) writes, overflow iff n > 8.
  task automatic load_image(input logic [15:0] hdr, input int gap_max);
    int n, nw;
    logic [2:0] pc;
    n  = stim_q.size();
    nw = (n > 8) ? 8 : n;
    pc = hdr[2:0];
    start_load();
    for (int i = 0; i <= n; i++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(1, gap_max) : 0;
      send_beat((i == 0) ? hdr : stim_q[i-1], (i == n), g);
    end
    for (int i = 0; i < nw; i++) exp_mem[i] = stim_q[i];
    if (n > 8) begin
      chk("ovf_err", err_overflow, 1);
      chk("ovf_cpu_rst", cpu_rst, 1);
      chk("ovf_in_ready", in_ready, 0);
      chk("ovf_mem_we", mem_we, 0);
      chk("ovf_wc", word_count, 8);
      @(negedge clk);
      chk("ovf_hold_err", err_overflow, 1);
      chk("ovf_no_kick", ovr_cnt, 0);
    end else begin
      chk("last_mem_we", mem_we, (n > 0) ? 1 : 0);
      chk("drain_cpu_rst", cpu_rst, 1);
      chk("drain_in_ready", in_ready, 0);
      @(negedge clk);
      chk("kick_cpu_rst", cpu_rst, 0);
      chk("kick_override", pc_manual_override, 1);
      chk("kick_pc", manual_pc, pc);
      chk("kick_done", done, 0);
      @(negedge clk);
      chk("run_override", pc_manual_override, 0);
      chk("run_done", done, 1);
      chk("run_cpu_rst", cpu_rst, 0);
      chk("run_pc", manual_pc, pc);
      chk("run_wc", word_count, n);
      chk("ovr_pulse_cnt", ovr_cnt, 1);
    end
    chk("write_cnt", obs_addr.size(), nw);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      chk("write_addr", obs_addr[i], i);
      chk("write_data", obs_data[i], stim_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    for (int i = 0; i < 8; i++) begin tb_mem[i] = '0; exp_mem[i] = '0; end
    #12;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {err_overflow, pc_manual_override, manual_pc, mem_addr, mem_wdata, word_count}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Normal load, then reload from RUN with back-pressure gaps.
    stim_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    load_image(16'h0003, 0);
    load_image(16'hFFF1, 3);

    // Full depth succeeds; one extra word overflows.
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'($urandom));
    load_image(16'h0006, 0);
    stim_q.push_back(16'hDEAD);
    load_image(16'h0002, 1);

    // Header-only restart.
    stim_q.delete();
    load_image(16'h0005, 0);

    // Random loads, including overflow and header-only cases.
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 9);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(16'($urandom));
      load_image(16'($urandom), $urandom_range(0, 2));
    end

    // Asynchronous reset mid-load after two words.
    start_load();
    send_beat(16'h0004, 1'b0, 0);
    send_beat(16'hA5A5, 1'b0, 0);
    send_beat(16'h5A5A, 1'b0, 0);
    exp_mem[0] = 16'hA5A5;
    exp_mem[1] = 16'h5A5A;
    chk("midload_mem_we", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_wc", word_count, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", cpu_rst, 1);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Recovery from IDLE after reset.
    stim_q = '{16'hBEEF, 16'hCAFE};
    load_image(16'h0007, 2);

    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("mem_image", tb_mem[i], exp_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
